// File: rtl/aes128_inv_iter_ctrl.sv
// Iterative AES-128 inverse cipher: one shared inverse round per cycle, fed from
// an 11-entry round-key store that can be reused across blocks under the same key.
module aes128_inv_iter_ctrl #(
  parameter int REUSE_KEY_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] ciphertext,
  input  logic [0:127] key,
  input  logic         key_new,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] plaintext,
  output logic         busy,
  output logic         key_loaded
);

  // Both ports are valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; the source holds valid and data steady until that edge.

  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_ROUND, S_DONE} state_t;

  state_t       state, state_nx;
  logic [3:0]   kcnt, rcnt;
  logic [127:0] st, kreg, pt_q;
  logic [127:0] rk [0:10];
  logic         ov_q, kl_q;
  logic         accept, need_exp;
  logic [127:0] ct_w, key_w, rk_sel, rk_next, round_x;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // Byte n of a block sits at [127-8n -: 8]; bytes are column-major (row + 4*col).
  function automatic logic [127:0] inv_shift_row(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_byte(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [7:0] imc_coef(input int k);
    case (k)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [127:0] inv_mix_col(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(imc_coef((j - i + 4) % 4), s[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+i) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign ct_w       = ciphertext;
  assign key_w      = key;
  assign plaintext  = pt_q;
  assign out_valid  = ov_q;
  assign key_loaded = kl_q;
  assign in_ready   = rst_n && (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign accept     = in_valid && in_ready;
  assign need_exp   = key_new || (REUSE_KEY_EN == 0) || !kl_q;

  // Rounds consume the schedule backwards: round r uses rk[10-r].
  assign rk_sel  = rk[4'd10 - rcnt];
  assign rk_next = key_expand(kreg, rcon_of(kcnt));
  assign round_x = inv_sub_byte(inv_shift_row(st)) ^ rk_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = need_exp ? S_KEXP : S_ROUND;
      S_KEXP:  if (kcnt == 4'd10) state_nx = S_ROUND;
      S_ROUND: if (rcnt == 4'd10) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcnt <= 4'd0;
      rcnt <= 4'd0;
      st   <= '0;
      kreg <= '0;
      pt_q <= '0;
      ov_q <= 1'b0;
      kl_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          st   <= ct_w;
          rcnt <= 4'd0;
          kcnt <= need_exp ? 4'd1 : 4'd0;
          if (need_exp) begin
            kreg <= key_w;
            kl_q <= 1'b0;
          end
        end
        S_KEXP: begin
          kreg <= rk_next;
          if (kcnt == 4'd10) begin
            kcnt <= 4'd0;
            kl_q <= 1'b1;
          end else begin
            kcnt <= kcnt + 4'd1;
          end
        end
        S_ROUND: begin
          if (rcnt == 4'd0) begin
            st <= st ^ rk_sel;
          end else if (rcnt == 4'd10) begin
            pt_q <= round_x;
            ov_q <= 1'b1;
          end else begin
            st <= inv_mix_col(round_x);
          end
          rcnt <= (rcnt == 4'd10) ? 4'd0 : rcnt + 4'd1;
        end
        S_DONE: if (out_ready) ov_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Round-key store carries no reset; key_loaded qualifies its contents.
  always_ff @(posedge clk) begin
    if (accept && need_exp) rk[0] <= key_w;
    else if (state == S_KEXP) rk[kcnt] <= rk_next;
  end

endmodule

// File: tb/tb_aes128_inv_iter_ctrl.sv
// Bench for aes128_inv_iter_ctrl: FIPS-197 / SP800-38A vectors, key reuse,
// backpressure, mid-operation reset and a REUSE_KEY_EN=0 instance.
module tb_aes128_inv_iter_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] SP_CT1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] SP_PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] SP_CT2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] SP_PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (key reuse enabled)
  logic         in_valid = 1'b0, key_new = 1'b0, out_ready = 1'b1;
  logic [127:0] ciphertext = '0, key = '0;
  logic         in_ready, out_valid, busy, key_loaded;
  logic [127:0] plaintext;

  aes128_inv_iter_ctrl #(.REUSE_KEY_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .key(key), .key_new(key_new),
    .out_valid(out_valid), .out_ready(out_ready), .plaintext(plaintext),
    .busy(busy), .key_loaded(key_loaded)
  );

  // second DUT with key reuse disabled
  logic         in_valid2 = 1'b0, key_new2 = 1'b0, out_ready2 = 1'b1;
  logic [127:0] ciphertext2 = '0, key2 = '0;
  logic         in_ready2, out_valid2, busy2, key_loaded2;
  logic [127:0] plaintext2;

  aes128_inv_iter_ctrl #(.REUSE_KEY_EN(0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .ciphertext(ciphertext2), .key(key2), .key_new(key_new2),
    .out_valid(out_valid2), .out_ready(out_ready2), .plaintext(plaintext2),
    .busy(busy2), .key_loaded(key_loaded2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // scoreboard
  logic [127:0] exp_q[$];
  int           lat_q[$];
  bit           neq_q[$];
  int           acc_cyc = 0;
  logic         ov_prev = 1'b0;
  logic [127:0] e_pt;
  int           e_lat;
  bit           e_neq;

  always @(negedge clk) begin
    if (rst_n && out_valid && !ov_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected no output", plaintext);
      end else begin
        e_pt  = exp_q.pop_front();
        e_lat = lat_q.pop_front();
        e_neq = neq_q.pop_front();
        if (e_neq) begin
          n_checks++;
          if (plaintext == e_pt) begin
            n_fail++;
            $display("FAIL wrong_key_pt: got %h required any value but %h", plaintext, e_pt);
          end
        end else begin
          check("plaintext", plaintext, e_pt);
        end
        check_int("latency", cyc - acc_cyc, e_lat);
      end
    end
    ov_prev <= out_valid;
  end

  // driver tasks
  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic kn,
                      input logic [127:0] pt, input int lat, input bit neq, input bit push);
    int t;
    @(negedge clk);
    key = k; ciphertext = c; key_new = kn; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check_int("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    // scramble inputs while busy; the DUT must ignore them
    key        = {$urandom, $urandom, $urandom, $urandom};
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    key_new    = 1'($urandom_range(0, 1));
    check_int("busy_after_accept", int'(busy), 1);
    check_int("in_ready_after_accept", int'(in_ready), 0);
    if (push) begin
      exp_q.push_back(pt);
      lat_q.push_back(lat);
      neq_q.push_back(neq);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check_int("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_key_loaded", int'(key_loaded), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_in_ready", int'(in_ready), 0);
    check("rst_plaintext", plaintext, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    lat_q.delete();
    neq_q.delete();
    @(negedge clk);
    check_int("in_ready_after_reset", int'(in_ready), 1);
  endtask

  task automatic run_nr(input logic [127:0] k, input logic [127:0] c, input logic [127:0] pt);
    int t;
    @(negedge clk);
    key2 = k; ciphertext2 = c; key_new2 = 1'b0; in_valid2 = 1'b1;
    t = 0;
    while (!in_ready2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready2) begin
      check_int("nr_accept_timeout", 0, 1);
      in_valid2 = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    t = 0;
    while (!out_valid2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_int("nr_latency", t, 21);
    check("nr_plaintext", plaintext2, pt);
    check_int("nr_key_loaded", int'(key_loaded2), 1);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic         kn;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t;
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    vecs[0] = '{C1_KEY, C1_CT, 1'b1, C1_PT, 21};
    vecs[1] = '{{128{1'b1}}, C1_CT, 1'b0, C1_PT, 11};
    vecs[2] = '{B_KEY, B_CT, 1'b1, B_PT, 21};
    vecs[3] = '{128'h0, SP_CT1, 1'b0, SP_PT1, 11};
    vecs[4] = '{B_KEY, SP_CT2, 1'b1, SP_PT2, 21};
    vecs[5] = '{C1_KEY, SP_CT1, 1'b0, SP_PT1, 11};

    // reset state
    #2 rst_n = 1'b0;
    #1;
    check_int("init_in_ready", int'(in_ready), 0);
    check_int("init_out_valid", int'(out_valid), 0);
    check_int("init_busy", int'(busy), 0);
    check_int("init_key_loaded", int'(key_loaded), 0);
    check("init_plaintext", plaintext, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_int("init_in_ready_release", int'(in_ready), 1);

    // table-driven vectors
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].key, vecs[i].ct, vecs[i].kn, vecs[i].pt, vecs[i].lat, 1'b0, 1'b1);
      wait_drain();
      check_int("key_loaded_after_block", int'(key_loaded), 1);
    end

    // stored schedule (FIPS-197 B key) must be used, not the C.1 key on the bus
    send(C1_KEY, C1_CT, 1'b0, C1_PT, 11, 1'b1, 1'b1);
    wait_drain();

    // backpressure: 7 extra cycles with out_ready low and a competing in_valid
    out_ready = 1'b0;
    send(C1_KEY, SP_CT2, 1'b0, SP_PT2, 11, 1'b0, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    in_valid = 1'b1; ciphertext = C1_CT; key = C1_KEY; key_new = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_int("bp_out_valid", int'(out_valid), 1);
      check("bp_plaintext", plaintext, SP_PT2);
      check_int("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check_int("bp_handoff_out_valid", int'(out_valid), 0);
    check_int("bp_handoff_in_ready", int'(in_ready), 1);
    check_int("bp_handoff_busy", int'(busy), 0);
    repeat (25) @(negedge clk);
    check_int("bp_no_second_accept", int'(busy), 0);

    // reset in the middle of key expansion
    send(C1_KEY, C1_CT, 1'b1, C1_PT, 21, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check_int("mid_kexp_busy", int'(busy), 1);
    do_reset();
    send(C1_KEY, C1_CT, 1'b0, C1_PT, 21, 1'b0, 1'b1);
    wait_drain();

    // reset in the middle of rounds on a reused schedule
    send(128'h0, SP_CT1, 1'b0, SP_PT1, 11, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_int("mid_round_key_loaded", int'(key_loaded), 1);
    do_reset();
    send(B_KEY, B_CT, 1'b0, B_PT, 21, 1'b0, 1'b1);
    wait_drain();

    // REUSE_KEY_EN = 0: every block expands the key on the bus
    run_nr(C1_KEY, C1_CT, C1_PT);
    run_nr(B_KEY, B_CT, B_PT);
    run_nr(B_KEY, SP_CT1, SP_PT1);
    run_nr(C1_KEY, C1_CT, C1_PT);

    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes128_inv_iter_ctrl.md
# aes128_inv_iter_ctrl

Iterative AES-128 decryption engine and controller. It accepts one ciphertext/key pair through a valid/ready handshake and expands the key schedule into an internal 11-entry round-key store. It then drives a single shared inverse-round datapath (inv_shift_row, inv_sub_byte, inv_mix_col, key_expand) for one round per cycle and returns the plaintext through a second valid/ready handshake. It is the area-reduced, sequenced counterpart of the fully unrolled combinational inverse cipher, and includes key-schedule reuse for back-to-back blocks under the same key.

## Interface
Parameters:
- REUSE_KEY_EN, default 1: 1 honours key_new = 0 (stored schedule reused); 0 forces key expansion on every block.

Ports:
- clk, input, 1: the only clock; all state on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: ciphertext/key/key_new are valid.
- in_ready, output, 1: high only in IDLE.
- ciphertext, input, [0:127]: block to decrypt; bit 0 = MSB of byte 0.
- key, input, [0:127]: cipher key (round key 0).
- key_new, input, 1: 1 = expand `key`; 0 = reuse stored schedule (`key` ignored).
- out_valid, output, 1: plaintext is valid.
- out_ready, input, 1: consumer accepts plaintext.
- plaintext, output, [0:127]: registered result.
- busy, output, 1: high in KEXP, ROUND or DONE.
- key_loaded, output, 1: a complete schedule is stored.

## Operation
- Accept occurs on a rising edge with in_valid && in_ready. At accept, latch ciphertext into the state register. When expanding, write key into rk[0].
- Expansion is required when key_new = 1, when REUSE_KEY_EN = 0, or when key_loaded = 0. Otherwise skip straight to ROUND.
- FSM: IDLE -> KEXP (expansion needed) or ROUND; KEXP -> ROUND after rk[10] is written; ROUND -> DONE after round 10; DONE -> IDLE on out_ready.
- KEXP uses round counter k = 1..10, one per cycle: rk[k] <= key_expand(rk[k-1], rcon_k). rcon sequence is 01,02,04,08,10,20,40,80,1b,36 in byte 0.
- At the start of KEXP, clear key_loaded. Set it on the edge that writes rk[10].
- ROUND uses counter r = 0..10, one per cycle:
  - r = 0: state <= state ^ rk[10].
  - r = 1..9: state <= inv_mix_col(inv_sub_byte(inv_shift_row(state)) ^ rk[10-r]).
  - r = 10: plaintext <= inv_sub_byte(inv_shift_row(state)) ^ rk[0]; out_valid <= 1.
- DONE: hold plaintext and out_valid stable until out_ready is high on an edge. On that edge, out_valid <= 0 and go to IDLE.
- Inputs are sampled only at accept; changes during busy are ignored.
- Round-key store is plain registers with no reset requirement. Contents are meaningful only while key_loaded = 1.

## Timing
- Reset values: in_ready 0 while rst_n low, 1 from the first cycle after release (IDLE); out_valid 0; plaintext 0; busy 0; key_loaded 0; FSM IDLE; counters 0.
- Accept edge = E0.
- With expansion: KEXP occupies E1..E10; ROUND occupies E11..E21. out_valid rises after E21, so latency is 21 cycles.
- Without expansion: ROUND occupies E1..E11. out_valid rises after E11, so latency is 11 cycles.
- If out_ready is already high when out_valid rises, handoff is at the next edge. in_ready returns one cycle after handoff, giving a minimum initiation interval of 23 (expand) / 13 (reuse) cycles.
- in_valid during busy is not accepted; the source holds it.
- Reset mid-operation (any state) has these immediate effects:
  - FSM goes to IDLE.
  - out_valid drops.
  - key_loaded drops, forcing expansion on the next block.
  - Any partial result is discarded.
- key_new = 0 with key_loaded = 0 behaves exactly as key_new = 1.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, key_new 1, out_ready 1 -> pt 00112233445566778899aabbccddeeff, out_valid high exactly 21 cycles after accept.
- Key reuse: after C.1, send the same ct with key_new 0 and key bus driven to all-ones -> same pt, latency 11.
- Key change: FIPS-197 B, key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32, key_new 1 -> pt 3243f6a8885a308d313198a2e0370734. Then C.1 ct with key_new 0 -> must NOT equal the C.1 pt.
- Backpressure: hold out_ready 0 for 7 cycles -> out_valid and pt stable throughout, in_ready 0, no second accept. Release -> one handoff, in_ready 1 the cycle after.
- Reset mid-KEXP at cycle 5: out_valid 0, key_loaded 0. Next block with key_new 0 and the C.1 key -> expansion performed (latency 21), correct C.1 pt.
- REUSE_KEY_EN = 0 build: key_new 0 for all blocks -> every block has latency 21 and correct pt for the supplied key.
